// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: arbiter state type and round-robin selection shared by the frame arbiter
package axis_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
  localparam int MAX_INPUTS = 8;
  // Inputs beyond NUM_INPUTS are tied low, so wrapping modulo MAX_INPUTS picks
  // the same winner as wrapping modulo NUM_INPUTS.
  function automatic logic [MAX_INPUTS-1:0] rr_select(input logic [MAX_INPUTS-1:0] req,
                                                       input logic [2:0] last);
    logic [MAX_INPUTS-1:0] g;
    logic [2:0] idx;
    g = '0;
    for (int i = MAX_INPUTS; i >= 1; i--) begin
      idx = last + 3'(i);
      if (req[idx]) g = MAX_INPUTS'(1) << idx;
    end
    return g;
  endfunction
endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: two-entry registered AXI-Stream stage with registered s_tready
module axis_skid_buffer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tlast,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready
);
  logic [DATA_WIDTH-1:0] skid_data;
  logic skid_last, skid_valid, out_free, s_fire;
  assign out_free = ~m_tvalid | m_tready;
  assign s_fire = s_tvalid & s_tready;
  // Output refills from the skid entry first; a stalled output parks the incoming beat in the skid entry
  always_ff @(posedge clk) begin
    if (reset) begin
      m_tvalid <= 1'b0;
      m_tlast <= 1'b0;
      m_tdata <= '0;
      skid_valid <= 1'b0;
      skid_last <= 1'b0;
      skid_data <= '0;
      s_tready <= 1'b0;
    end else begin
      s_tready <= out_free | ~(skid_valid | s_fire);
      if (out_free) begin
        m_tvalid <= skid_valid | s_fire;
        m_tdata <= skid_valid ? skid_data : s_tdata;
        m_tlast <= skid_valid ? skid_last : s_tlast;
        skid_valid <= 1'b0;
      end else if (s_fire) begin
        skid_valid <= 1'b1;
        skid_data <= s_tdata;
        skid_last <= s_tlast;
      end
    end
  end
endmodule

// File: rtl/axis_frame_arbiter.sv
// axis_frame_arbiter: frame-atomic round-robin arbiter feeding one registered AXI-Stream output
module axis_frame_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_INPUTS-1:0]            s_axis_tvalid,
  input  logic [NUM_INPUTS-1:0]            s_axis_tlast,
  output logic [NUM_INPUTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic                             m_axis_tvalid,
  output logic                             m_axis_tlast,
  input  logic                             m_axis_tready,
  output logic [NUM_INPUTS-1:0]            grant,
  output logic                             busy
);
  arb_state_t state, state_nxt;
  logic [2:0] last_grant, gidx;
  logic [MAX_INPUTS-1:0] rr_full;
  logic [DATA_WIDTH-1:0] sel_data;
  logic sel_valid, sel_last, sk_ready, fire, unused_rr;
  assign rr_full = rr_select(MAX_INPUTS'(s_axis_tvalid), last_grant);
  assign unused_rr = ^rr_full;
  assign fire = sel_valid & sk_ready;
  // Mux the owner's beat toward the skid buffer and remember its index
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    sel_valid = 1'b0;
    gidx = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant[i]) begin
        sel_data = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_last = s_axis_tlast[i];
        sel_valid = s_axis_tvalid[i];
        gidx = 3'(i);
      end
    end
  end
  // State, current owner and round-robin pointer; the pointer only moves when a frame completes
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
      grant <= '0;
      last_grant <= 3'(NUM_INPUTS - 1);
    end else begin
      state <= state_nxt;
      if (state == ARB_IDLE) grant <= rr_full[NUM_INPUTS-1:0];
      else if (fire && sel_last) begin
        grant <= '0;
        last_grant <= gidx;
      end
    end
  end
  // Idle arbitrates for one cycle; busy holds until the owner's tlast beat is taken
  always_comb begin
    state_nxt = (state == ARB_IDLE) ? ((|s_axis_tvalid) ? ARB_BUSY : ARB_IDLE)
                                    : ((fire && sel_last) ? ARB_IDLE : ARB_BUSY);
  end
  // Only the owner sees the buffer's registered ready
  always_comb begin
    busy = (state == ARB_BUSY);
    s_axis_tready = (busy && sk_ready) ? grant : '0;
  end
  axis_skid_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk      (clk),
    .reset    (reset),
    .s_tdata  (sel_data),
    .s_tlast  (sel_last),
    .s_tvalid (sel_valid),
    .s_tready (sk_ready),
    .m_tdata  (m_axis_tdata),
    .m_tlast  (m_axis_tlast),
    .m_tvalid (m_axis_tvalid),
    .m_tready (m_axis_tready)
  );
endmodule

// File: tb/tb_axis_frame_arbiter.sv
// tb_axis_frame_arbiter: directed frames checked against a queue-based arbitration model
module tb_axis_frame_arbiter;
  localparam int N = 2;
  localparam int DW = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N*DW-1:0] s_axis_tdata;
  logic [N-1:0] s_axis_tvalid, s_axis_tlast, s_axis_tready, grant;
  logic [DW-1:0] m_axis_tdata;
  logic m_axis_tvalid, m_axis_tlast, m_axis_tready, busy;
  always #5 clk = ~clk;
  axis_frame_arbiter #(.NUM_INPUTS(N), .DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .grant         (grant),
    .busy          (busy)
  );
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [10:0] src_q [N][$];
  int pause [N];
  logic gate [N];
  int popped [N];
  int acc_cnt [N];
  logic rdy_q [$];
  logic [8:0] exp_q [$];
  logic [8:0] out_log [$];
  int out_cyc [$];
  logic [N-1:0] gr_log [$];
  logic [8:0] lit_q [$];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [N-1:0] rr_model(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (req[i]) return N'(1) << i;
    end
    return '0;
  endfunction
  // Monitor and model: runs mid-cycle so every value is stable for the coming edge
  logic prev_rst = 1'b1;
  logic prev_stall = 1'b0;
  logic exp_gv = 1'b0;
  logic [N-1:0] exp_grant = '0;
  logic [N-1:0] prev_grant = '0;
  logic [8:0] prev_beat = '0;
  int mdl_last = N - 1;
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      exp_gv = 1'b0;
      prev_stall = 1'b0;
      mdl_last = N - 1;
      prev_grant = '0;
      prev_rst = 1'b1;
    end else begin
      if (prev_rst) begin
        chk("reset_grant", 32'(grant), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_s_tready", 32'(s_axis_tready), 0);
        chk("reset_m_out", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, 0);
      end
      prev_rst = 1'b0;
      if (exp_gv) chk("grant", 32'(grant), 32'(exp_grant));
      chk("busy", 32'(busy), 32'(|grant));
      chk("tready_owner", 32'(s_axis_tready & ~grant), 0);
      if (prev_stall) chk("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, prev_beat});
      exp_grant = grant;
      if (grant == '0) begin
        if (|s_axis_tvalid) exp_grant = rr_model(s_axis_tvalid, mdl_last);
      end else begin
        for (int i = 0; i < N; i++) begin
          if (grant[i] && s_axis_tvalid[i] && s_axis_tready[i]) begin
            exp_q.push_back({s_axis_tlast[i], s_axis_tdata[i*DW +: DW]});
            if (s_axis_tlast[i]) begin
              mdl_last = i;
              exp_grant = '0;
            end
          end
        end
      end
      exp_gv = 1'b1;
      for (int i = 0; i < N; i++) if (s_axis_tvalid[i] && s_axis_tready[i]) acc_cnt[i]++;
      if (m_axis_tvalid && m_axis_tready) begin
        out_log.push_back({m_axis_tlast, m_axis_tdata});
        out_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_extra: got 0x%0h, expected no beat (cycle %0d)", {m_axis_tlast, m_axis_tdata}, cyc);
        end else chk("out_beat", {m_axis_tlast, m_axis_tdata}, exp_q.pop_front());
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat = {m_axis_tlast, m_axis_tdata};
      if (grant != '0 && grant != prev_grant) gr_log.push_back(grant);
      prev_grant = grant;
    end
  end
  task automatic present();
    for (int i = 0; i < N; i++) begin
      s_axis_tvalid[i] = gate[i] && src_q[i].size() > 0;
      s_axis_tdata[i*DW +: DW] = src_q[i].size() > 0 ? src_q[i][0][7:0] : '0;
      s_axis_tlast[i] = src_q[i].size() > 0 && src_q[i][0][8];
    end
  endtask
  task automatic advance();
    for (int i = 0; i < N; i++) begin
      while (popped[i] < acc_cnt[i]) begin
        if (src_q[i].size() > 0) void'(src_q[i].pop_front());
        popped[i]++;
        if (src_q[i].size() > 0) pause[i] = int'(src_q[i][0][10:9]);
      end
      if (pause[i] > 0) begin
        gate[i] = 1'b0;
        pause[i]--;
      end else gate[i] = 1'b1;
    end
    m_axis_tready = rdy_q.size() > 0 ? rdy_q.pop_front() : 1'b1;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    advance();
    present();
  endtask
  task automatic push(input int i, input logic [7:0] d, input logic l, input logic [1:0] gap);
    src_q[i].push_back({gap, l, d});
  endtask
  task automatic clear_logs();
    out_log.delete();
    out_cyc.delete();
    gr_log.delete();
    lit_q.delete();
  endtask
  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      popped[i] = acc_cnt[i];
      pause[i] = 0;
      gate[i] = 1'b1;
    end
    present();
  endtask
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((src_q[0].size() > 0 || src_q[1].size() > 0 || exp_q.size() > 0 ||
            grant != '0 || m_axis_tvalid) && n < 300) begin
      step();
      n++;
    end
    chk({name, "_timeout"}, 32'(n < 300), 1);
    repeat (2) step();
  endtask
  task automatic chk_log(input string name);
    chk({name, "_len"}, out_log.size(), lit_q.size());
    for (int k = 0; k < lit_q.size() && k < out_log.size(); k++) chk(name, 32'(out_log[k]), 32'(lit_q[k]));
  endtask
  task automatic chk_gr(input string name, input logic [N-1:0] a, input logic [N-1:0] b);
    chk({name, "_len"}, gr_log.size(), 2);
    if (gr_log.size() >= 2) begin
      chk({name, "_first"}, 32'(gr_log[0]), 32'(a));
      chk({name, "_second"}, 32'(gr_log[1]), 32'(b));
    end
  endtask
  int t0;
  initial begin
    s_axis_tdata = '0;
    s_axis_tvalid = '0;
    s_axis_tlast = '0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < N; i++) begin
      pause[i] = 0;
      gate[i] = 1'b1;
      popped[i] = 0;
      acc_cnt[i] = 0;
    end
    repeat (3) step();
    reset = 1'b0;
    step();
    // single 4-beat frame from input 0
    clear_logs();
    t0 = cyc;
    for (int k = 0; k < 4; k++) push(0, 8'(17 * (k + 1)), k == 3, 2'd0);
    present();
    step();
    chk("t1_grant", 32'(grant), 1);
    wait_idle("t1");
    for (int k = 0; k < 4; k++) lit_q.push_back({k == 3, 8'(17 * (k + 1))});
    chk_log("t1_data");
    if (out_cyc.size() == 4) begin
      chk("t1_first_latency", out_cyc[0] - t0, 2);
      chk("t1_back_to_back", out_cyc[3] - out_cyc[0], 3);
    end
    chk("t1_grant_after", 32'(grant), 0);
    // both inputs hold 3-beat frames from reset
    reset = 1'b1;
    clear_src();
    step();
    clear_logs();
    for (int k = 0; k < 3; k++) push(0, 8'(8'hA0 + k), k == 2, 2'd0);
    for (int k = 0; k < 3; k++) push(1, 8'(8'hB0 + k), k == 2, 2'd0);
    present();
    step();
    reset = 1'b0;
    wait_idle("t2");
    for (int k = 0; k < 3; k++) lit_q.push_back({k == 2, 8'(8'hA0 + k)});
    for (int k = 0; k < 3; k++) lit_q.push_back({k == 2, 8'(8'hB0 + k)});
    chk_log("t2_data");
    if (out_cyc.size() == 6) chk("t2_one_bubble", out_cyc[3] - out_cyc[2], 2);
    chk_gr("t2_grants", 2'b01, 2'b10);
    // six single-beat frames alternate between the inputs
    clear_logs();
    for (int k = 0; k < 3; k++) begin
      push(0, 8'(8'h00 + k), 1'b1, 2'd0);
      push(1, 8'(8'h10 + k), 1'b1, 2'd0);
    end
    present();
    wait_idle("t3");
    for (int k = 0; k < 3; k++) begin
      lit_q.push_back({1'b1, 8'(8'h00 + k)});
      lit_q.push_back({1'b1, 8'(8'h10 + k)});
    end
    chk_log("t3_data");
    chk("t3_grant_changes", gr_log.size(), 6);
    // 5-beat frame from input 1 with downstream stalls
    clear_logs();
    for (int k = 0; k < 5; k++) push(1, 8'(8'hC0 + k), k == 4, 2'd0);
    rdy_q.push_back(1'b1);
    rdy_q.push_back(1'b1);
    rdy_q.push_back(1'b1);
    rdy_q.push_back(1'b0);
    rdy_q.push_back(1'b0);
    rdy_q.push_back(1'b1);
    present();
    wait_idle("t4");
    for (int k = 0; k < 5; k++) lit_q.push_back({k == 4, 8'(8'hC0 + k)});
    chk_log("t4_data");
    if (out_cyc.size() == 5) chk("t4_stall_span", out_cyc[4] - out_cyc[0], 6);
    // input 1 pauses mid-frame while input 0 waits
    clear_logs();
    push(1, 8'hD0, 1'b0, 2'd0);
    push(1, 8'hD1, 1'b0, 2'd0);
    push(1, 8'hD2, 1'b0, 2'd3);
    push(1, 8'hD3, 1'b1, 2'd0);
    present();
    step();
    step();
    push(0, 8'hE0, 1'b0, 2'd0);
    push(0, 8'hE1, 1'b1, 2'd0);
    present();
    wait_idle("t5");
    for (int k = 0; k < 4; k++) lit_q.push_back({k == 3, 8'(8'hD0 + k)});
    lit_q.push_back({1'b0, 8'hE0});
    lit_q.push_back({1'b1, 8'hE1});
    chk_log("t5_data");
    chk_gr("t5_grants", 2'b10, 2'b01);
    // reset in the middle of input 1's frame
    clear_logs();
    t0 = acc_cnt[1];
    for (int k = 0; k < 4; k++) push(1, 8'(8'hF0 + k), k == 3, 2'd0);
    present();
    for (int n = 0; n < 50 && acc_cnt[1] - t0 < 2; n++) step();
    chk("t6_two_beats", acc_cnt[1] - t0, 2);
    reset = 1'b1;
    clear_src();
    step();
    reset = 1'b0;
    chk("t6_mvalid_after_reset", 32'(m_axis_tvalid), 0);
    chk("t6_grant_after_reset", 32'(grant), 0);
    clear_logs();
    push(0, 8'h60, 1'b1, 2'd0);
    push(1, 8'h70, 1'b1, 2'd0);
    present();
    wait_idle("t6");
    lit_q.push_back({1'b1, 8'h60});
    lit_q.push_back({1'b1, 8'h70});
    chk_log("t6_data");
    chk_gr("t6_grants", 2'b01, 2'b10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axis_frame_arbiter.md
Name: axis_frame_arbiter

Overview:
- Round-robin arbiter that shares one AXI-Stream byte path, such as the MAC TX datapath, between NUM_INPUTS frame sources.
- Grants are frame-atomic: once an input wins, it owns the output until its tlast beat is accepted.
- Output is registered through a skid buffer, giving full throughput within a frame and timing isolation toward the MAC.

Parameters:
NUM_INPUTS, 2, number of requesting streams (2..8)
DATA_WIDTH, 8, tdata width per stream in bits

Ports:
clk  in  1  single clock for all logic
reset  in  1  synchronous, active-high reset
s_axis_tdata  in  NUM_INPUTS*DATA_WIDTH  input data, input i at [i*DATA_WIDTH +: DATA_WIDTH]
s_axis_tvalid  in  NUM_INPUTS  per-input valid
s_axis_tlast  in  NUM_INPUTS  per-input end of frame
s_axis_tready  out  NUM_INPUTS  per-input ready; only the granted bit can be 1
m_axis_tdata  out  DATA_WIDTH  arbitrated output data
m_axis_tvalid  out  1  output valid
m_axis_tlast  out  1  output end of frame
m_axis_tready  in  1  downstream ready
grant  out  NUM_INPUTS  one-hot current owner; all zero when idle
busy  out  1  high while a frame is granted

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-high, port name reset.
- Reset values:
  - state=IDLE, grant=0, busy=0, s_axis_tready=0.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - last_grant=NUM_INPUTS-1, so input 0 has first priority.
- State IDLE:
  - s_axis_tready=0.
  - If any s_axis_tvalid bit is set, select the first set bit searching upward from last_grant+1, wrapping modulo NUM_INPUTS.
  - Register the one-hot result into grant, go to BUSY.
  - No beat transfers in the IDLE cycle.
- State BUSY:
  - s_axis_tready[g] = skid buffer input ready; all other bits 0.
  - The input beat (tdata, tlast) of input g is muxed into the skid buffer.
  - On a handshake with tlast=1: set last_grant=g, clear grant, go to IDLE.
  - This gives exactly one bubble cycle between consecutive frames.
- A source dropping tvalid mid-frame keeps its grant; the arbiter waits indefinitely. There is no timeout.
- New requests arriving during BUSY are ignored until the next IDLE cycle.
- Latency: a beat accepted at an input on cycle N is visible on m_axis on cycle N+1 if the skid buffer is empty. Sustained throughput is 1 beat/cycle while m_axis_tready=1.
- Backpressure:
  - m_axis holds tdata/tlast stable while tvalid=1 and tready=0.
  - The skid buffer absorbs one extra beat; s_axis_tready is registered, with no combinational path from m_axis_tready.
- Single-beat frame (tvalid=1, tlast=1 on the first beat): BUSY lasts one handshake, then IDLE.
- Fairness: with all inputs continuously requesting, grants rotate 0,1,…,NUM_INPUTS-1,0.
- Reset mid-frame:
  - Flushes the skid buffer and drops grant; a partial frame on m_axis is truncated.
  - The next grant goes to input 0.

Decomposition:
- Package axis_arb_pkg holds:
  - arb_state_t enum {ARB_IDLE, ARB_BUSY}.
  - Function rr_select(req, last), returning a one-hot grant, with NUM_INPUTS-generic loops.
- One sub-module, axis_skid_buffer:
  - Parameter DATA_WIDTH (tdata plus tlast carried together), two-entry, full throughput.
  - Registered s_tready; same clk/reset convention.

Test Plan:
- Input 0 sends a 4-beat frame 0x11,0x22,0x33,0x44 with m_axis_tready=1 -> grant=01 one cycle after tvalid; bytes appear in order on consecutive cycles, first at 2 cycles after the initial tvalid; tlast only on 0x44; then grant=00.
- Inputs 0 and 1 both hold 3-beat frames (0xA0..A2, 0xB0..B2) from reset -> output sequence A0,A1,A2,bubble,B0,B1,B2; grant 01 then 10.
- Both inputs continuously requesting 1-beat frames for 6 frames -> output source order 0,1,0,1,0,1; tlast set on every beat.
- m_axis_tready toggles 1,0,0,1 during a 5-beat frame from input 1 -> no beat lost or duplicated; m_axis_tdata stable while stalled; input 0 tready stays 0 throughout.
- Granted input 1 deasserts tvalid for 3 cycles mid-frame while input 0 requests -> grant stays 10; input 0 is served only after input 1's tlast.
- reset asserted for 1 cycle after 2 of 4 beats of input 1's frame -> next cycle m_axis_tvalid=0, grant=00; with both inputs requesting afterwards, input 0 is granted first.
